tt_um_mode_counter: RTL and testbench

TT_UM_MODE_COUNTER -- requirements
Module: tt_um_mode_counter

---
 rtl/tt_um_mode_counter_if.sv | 12 +
 rtl/tt_um_mode_counter.sv | 106 ++++++++++
 tb/tb_tt_um_mode_counter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/tt_um_mode_counter_if.sv
// Tiny-Tapeout style pin bundle for the mode counter: load byte and control in, count byte and flags out.
interface tt_um_mode_counter_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_mode_counter.sv
// Prescaled HOLD/LOAD/UP/DOWN counter with byte-wise load/readout; count and tc/ovf/adv update one edge after the command, no backpressure.
// Define MODE_COUNTER_SAT_EN to saturate at the bounds instead of wrapping.
module tt_um_mode_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tt_um_mode_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    M_HOLD = 2'b00,
    M_LOAD = 2'b01,
    M_UP   = 2'b10,
    M_DOWN = 2'b11
  } mode_e;

  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  if (WIDTH < 8 || WIDTH > 16) begin : g_bad_width
    $error("tt_um_mode_counter: WIDTH must be within 8..16");
  end
  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
    $error("tt_um_mode_counter: PRESCALE must be within 1..256");
  end

  mode_e            mode;
  mode_e            mode_q;
  logic             en;
  logic             bsel;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_eff;
  logic [PW-1:0]    pre_nxt;
  logic             tc;
  logic             ovf;
  logic             adv;
  logic             run;
  logic             advance;
  logic             at_bound;
  logic             load;
  logic [15:0]      count_ext;
  logic [15:0]      load_ext;

  assign mode = mode_e'(bus.uio_in[1:0]);
  assign en   = bus.uio_in[2];
  assign bsel = bus.uio_in[3];

  always_comb begin
    run      = en && (mode == M_UP || mode == M_DOWN);
    // A mode change discards any partial prescale count.
    pre_eff  = (mode != mode_q) ? '0 : pre;
    advance  = run && (pre_eff == PRE_LAST);
    pre_nxt  = (run && !advance) ? pre_eff + 1'b1 : '0;
    at_bound = (mode == M_UP) ? (count == CNT_MAX) : (count == '0);
    load     = en && (mode == M_LOAD);

    count_ext              = '0;
    count_ext[WIDTH-1:0]   = count;
    load_ext               = count_ext;
    if (bsel) load_ext[15:8] = bus.ui_in;
    else      load_ext[7:0]  = bus.ui_in;

    count_nxt = count;
    if (load) begin
      count_nxt = load_ext[WIDTH-1:0];
`ifdef MODE_COUNTER_SAT_EN
    end else if (advance && !at_bound) begin
`else
    end else if (advance) begin
`endif
      count_nxt = (mode == M_UP) ? count + 1'b1 : count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      pre    <= '0;
      mode_q <= M_HOLD;
      tc     <= 1'b0;
      ovf    <= 1'b0;
      adv    <= 1'b0;
    end else begin
      count  <= count_nxt;
      pre    <= pre_nxt;
      mode_q <= mode;
      adv    <= advance;
      tc     <= advance && at_bound;
      if (load)                     ovf <= 1'b0;
      else if (advance && at_bound) ovf <= 1'b1;
    end
  end

  // Upper load bits beyond WIDTH are intentionally dropped.
  wire unused = &{1'b0, bus.ena, bus.uio_in[7:4], load_ext};

  assign bus.uo_out  = bsel ? count_ext[15:8] : count_ext[7:0];
  assign bus.uio_out = {adv, ovf, (count == '0), tc, 4'b0000};
  assign bus.uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_mode_counter.sv
// Scoreboard bench for tt_um_mode_counter: 8-bit/1, 8-bit/4 and 12-bit/1 instances.
module tb_tt_um_mode_counter;

`ifdef MODE_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    string      tag;
    int         dut;
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  tt_um_mode_counter_if i8 ();
  tt_um_mode_counter_if i4 ();
  tt_um_mode_counter_if i12 ();

  tt_um_mode_counter #(.WIDTH(8),  .PRESCALE(1)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(i8));
  tt_um_mode_counter #(.WIDTH(8),  .PRESCALE(4)) u_dut4  (.clk(clk), .rst_n(rst_n), .bus(i4));
  tt_um_mode_counter #(.WIDTH(12), .PRESCALE(1)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(i12));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fl(input bit a, input bit o, input bit z, input bit t);
    return {a, o, z, t, 4'b0000};
  endfunction

  function automatic logic [7:0] get_uo(input int d);
    case (d)
      0:       return i8.uo_out;
      1:       return i4.uo_out;
      default: return i12.uo_out;
    endcase
  endfunction

  function automatic logic [7:0] get_uio(input int d);
    case (d)
      0:       return i8.uio_out;
      1:       return i4.uio_out;
      default: return i12.uio_out;
    endcase
  endfunction

  task automatic drive(input int d, input logic [7:0] ui, input logic [7:0] ctl);
    case (d)
      0:       begin i8.ui_in  = ui; i8.uio_in  = ctl; end
      1:       begin i4.ui_in  = ui; i4.uio_in  = ctl; end
      default: begin i12.ui_in = ui; i12.uio_in = ctl; end
    endcase
  endtask

  task automatic push(input string tag, input int d, input logic [7:0] uo, input logic [7:0] uio);
    exp_t e;
    e.tag = tag; e.dut = d; e.uo = uo; e.uio = uio;
    sb_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq({e.tag, ".uo"},  get_uo(e.dut),  e.uo);
      check_eq({e.tag, ".uio"}, get_uio(e.dut), e.uio);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    i8.ena = 1'b1; i4.ena = 1'b1; i12.ena = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 8'h00, 8'h00);

    // Reset state
    #12;
    check_eq("rst.uo8",   i8.uo_out,   8'h00);
    check_eq("rst.uio8",  i8.uio_out,  fl(0, 0, 1, 0));
    check_eq("rst.uo4",   i4.uo_out,   8'h00);
    check_eq("rst.uio4",  i4.uio_out,  fl(0, 0, 1, 0));
    check_eq("rst.uo12",  i12.uo_out,  8'h00);
    check_eq("rst.oe8",   i8.uio_oe,   8'hF0);
    check_eq("rst.oe12",  i12.uio_oe,  8'hF0);
    rst_n = 1'b1;

    // 8-bit, prescale 1: load, wrap/saturate, freeze, ovf clear, down bound
    drive(0, 8'hA5, 8'h05); push("load_a5", 0, 8'hA5, fl(0, 0, 0, 0)); step();
    drive(0, 8'hFE, 8'h05); push("load_fe", 0, 8'hFE, fl(0, 0, 0, 0)); step();
    drive(0, 8'h00, 8'h06);
    push("up1", 0, 8'hFF, fl(1, 0, 0, 0)); step();
    push("up2", 0, SAT ? 8'hFF : 8'h00, fl(1, 1, !SAT, 1)); step();
    push("up3", 0, SAT ? 8'hFF : 8'h01, fl(1, 1, 0, SAT)); step();
    drive(0, 8'h00, 8'h02); push("frozen", 0, SAT ? 8'hFF : 8'h01, fl(0, 1, 0, 0)); step();
    drive(0, 8'h00, 8'h05); push("load_00", 0, 8'h00, fl(0, 0, 1, 0)); step();
    drive(0, 8'h00, 8'h07); push("down_bnd", 0, SAT ? 8'h00 : 8'hFF, fl(1, 1, SAT, 1)); step();
    drive(0, 8'h00, 8'h04); push("hold", 0, SAT ? 8'h00 : 8'hFF, fl(0, 1, SAT, 0)); step();
    drive(0, 8'h77, 8'h0D); push("load_hi8", 0, 8'h00, fl(0, 0, SAT, 0)); step();
    drive(0, 8'h00, 8'h04); push("hi8_kept", 0, SAT ? 8'h00 : 8'hFF, fl(0, 0, SAT, 0)); step();
    drive(0, 8'h00, 8'h00);

    // Prescale 4: advance every fourth enabled cycle
    drive(1, 8'h00, 8'h06);
    for (int k = 1; k <= 8; k++) begin
      push($sformatf("pre4_%0d", k), 1, 8'(k / 4), fl(k % 4 == 0, 0, k < 4, 0));
      step();
    end
    // Switching UP->DOWN mid-prescale restarts the prescale window
    for (int k = 1; k <= 2; k++) begin
      push($sformatf("pre4_up_%0d", k), 1, 8'h02, fl(0, 0, 0, 0));
      step();
    end
    drive(1, 8'h00, 8'h07);
    for (int k = 1; k <= 4; k++) begin
      push($sformatf("pre4_dn_%0d", k), 1, (k == 4) ? 8'h01 : 8'h02, fl(k == 4, 0, 0, 0));
      step();
    end
    drive(1, 8'h00, 8'h00);

    // 12-bit: byte-wise load, truncation, full-width zero, down bound
    drive(2, 8'h34, 8'h05); push("w12_lo", 2, 8'h34, fl(0, 0, 0, 0)); step();
    drive(2, 8'h12, 8'h0D); push("w12_hi", 2, 8'h02, fl(0, 0, 0, 0)); step();
    drive(2, 8'h00, 8'h04); push("w12_lo_rd", 2, 8'h34, fl(0, 0, 0, 0)); step();
    drive(2, 8'h00, 8'h05); push("w12_clr_lo", 2, 8'h00, fl(0, 0, 0, 0)); step();
    drive(2, 8'h00, 8'h0D); push("w12_clr_hi", 2, 8'h00, fl(0, 0, 1, 0)); step();
    drive(2, 8'h00, 8'h07); push("w12_down", 2, SAT ? 8'h00 : 8'hFF, fl(1, 1, SAT, 1)); step();
    drive(2, 8'h00, 8'h0C); push("w12_hi_rd", 2, SAT ? 8'h00 : 8'h0F, fl(0, 1, SAT, 0)); step();
    drive(2, 8'h00, 8'h00);

    // Asynchronous reset mid-prescale
    drive(1, 8'h10, 8'h05); push("ld10", 1, 8'h10, fl(0, 0, 0, 0)); step();
    drive(1, 8'h00, 8'h06);
    for (int k = 1; k <= 2; k++) begin
      push($sformatf("pre_rst_%0d", k), 1, 8'h10, fl(0, 0, 0, 0));
      step();
    end
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async.uo",  i4.uo_out,  8'h00);
    check_eq("rst_async.uio", i4.uio_out, fl(0, 0, 1, 0));
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      push($sformatf("post_rst_%0d", k), 1, (k == 4) ? 8'h01 : 8'h00, fl(k == 4, 0, k < 4, 0));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
